// File: rtl/seven_seg_pkg.sv
// Shared types and glyph constants for the seven-segment scan controller.
// Segment order is {a,b,c,d,e,f,g}, bit 6 = a, active-high.
package seven_seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Glyphs for BCD 0..9; 6 carries the a tail, 9 carries the d tail.
    localparam logic [6:0] SEG_GLYPH [10] = '{
        7'b1111110,
        7'b0110000,
        7'b1101101,
        7'b1111001,
        7'b0110011,
        7'b1011011,
        7'b1011111,
        7'b1110000,
        7'b1111111,
        7'b1111011
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to seven-segment decoder; codes 10-15 are blank.
// Ports: bcd_i (4-bit digit), seg_o ({a..g}, active-high).
module seg7_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (bcd_i <= 4'd9) begin
            seg_o = SEG_GLYPH[bcd_i];
        end
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with blanking, leading-zero
// suppression and frame-synchronous (tear-free) display updates.
// Ports: clk, rst (sync, active-high), load/ready handshake,
// bcd_in/dp_in data, lz_en, seg/dp/an registered display outputs.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    output logic                    ready,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int DW   = 4 * NUM_DIGITS;
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int PMAX = (REFRESH_DIV > BLANK_CYCLES) ?
                          REFRESH_DIV : BLANK_CYCLES;
    localparam int PW   = $clog2(PMAX);

    localparam logic [PW-1:0] SHOW_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    state_e                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [DW-1:0]         disp_bcd_q, disp_bcd_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic [DW-1:0]         pend_bcd_q, pend_bcd_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                  pend_vld_q, pend_vld_d;
    logic                  ready_q, ready_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic                  commit;
    logic                  accept;
    logic                  suppress;
    logic [3:0]            cur_bcd;
    logic [6:0]            dec_seg;

    // Scan sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        phase_d = phase_q + 1'b1;
        unique case (state_q)
            BLANK: begin
                if (phase_q == BLANK_LAST) begin
                    state_d = SHOW;
                    phase_d = '0;
                end
            end
            SHOW: begin
                if (phase_q == SHOW_LAST) begin
                    state_d = BLANK;
                    phase_d = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Commit happens only at the frame boundary, so a frame is never torn.
    assign commit = (state_q == SHOW) && (idx_q == IDX_LAST) &&
                    (phase_q == SHOW_LAST);
    assign accept = load && ready_q;

    always_comb begin
        disp_bcd_d = disp_bcd_q;
        disp_dp_d  = disp_dp_q;
        pend_bcd_d = pend_bcd_q;
        pend_dp_d  = pend_dp_q;
        pend_vld_d = pend_vld_q;
        ready_d    = ready_q;
        if (commit) begin
            if (accept) begin
                // Load on the boundary bypasses the pending stage.
                disp_bcd_d = bcd_in;
                disp_dp_d  = dp_in;
            end else if (pend_vld_q) begin
                disp_bcd_d = pend_bcd_q;
                disp_dp_d  = pend_dp_q;
                pend_vld_d = 1'b0;
                ready_d    = 1'b1;
            end
        end else if (accept) begin
            pend_bcd_d = bcd_in;
            pend_dp_d  = dp_in;
            pend_vld_d = 1'b1;
            ready_d    = 1'b0;
        end
    end

    // Outputs track the next state so they change on the same edge.
    // SHOW is never entered on a commit edge, so disp_*_q is current.
    assign cur_bcd  = disp_bcd_q[{idx_d, 2'b00} +: 4];
    assign suppress = lz_en && (idx_d != '0) &&
                      ((disp_bcd_q >> {idx_d, 2'b00}) == '0);

    seg7_decode u_dec (
        .bcd_i (cur_bcd),
        .seg_o (dec_seg)
    );

    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        dp_d  = 1'b0;
        if (state_d == SHOW) begin
            an_d[idx_d] = 1'b0;
            seg_d       = suppress ? SEG_BLANK : dec_seg;
            dp_d        = disp_dp_q[idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BLANK;
            idx_q      <= '0;
            phase_q    <= '0;
            disp_bcd_q <= '0;
            disp_dp_q  <= '0;
            pend_bcd_q <= '0;
            pend_dp_q  <= '0;
            pend_vld_q <= 1'b0;
            ready_q    <= 1'b1;
            an_q       <= '1;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            phase_q    <= phase_d;
            disp_bcd_q <= disp_bcd_d;
            disp_dp_q  <= disp_dp_d;
            pend_bcd_q <= pend_bcd_d;
            pend_dp_q  <= pend_dp_d;
            pend_vld_q <= pend_vld_d;
            ready_q    <= ready_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign ready = ready_q;
    assign an    = an_q;
    assign seg   = seg_q;
    assign dp    = dp_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl (4 digits, 8/2 timing).
// Table vectors, directed corner sequences and a random run vs a model.
module tb_seven_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int SLOT  = RD + BC;
    localparam int FRAME = ND * SLOT;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic        ready;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .ready  (ready),
        .bcd_in (bcd_in),
        .dp_in  (dp_in),
        .lz_en  (lz_en),
        .seg    (seg),
        .dp     (dp),
        .an     (an)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: edge count since reset plus display contents.
    int          k = 0;
    logic [15:0] m_bcd = '0, p_bcd = '0;
    logic [3:0]  m_dp = '0, p_dp = '0;
    bit          m_pv = 0, m_ready = 1, m_lz = 0;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0: glyph = 7'b1111110;
            4'd1: glyph = 7'b0110000;
            4'd2: glyph = 7'b1101101;
            4'd3: glyph = 7'b1111001;
            4'd4: glyph = 7'b0110011;
            4'd5: glyph = 7'b1011011;
            4'd6: glyph = 7'b1011111;
            4'd7: glyph = 7'b1110000;
            4'd8: glyph = 7'b1111111;
            4'd9: glyph = 7'b1111011;
            default: glyph = 7'b0000000;
        endcase
    endfunction

    task automatic model_edge();
        bit acc;
        acc  = load && m_ready;
        m_lz = lz_en;
        if (rst) begin
            k = 0;
            m_bcd = '0; m_dp = '0;
            p_bcd = '0; p_dp = '0;
            m_pv = 0; m_ready = 1;
        end else begin
            k++;
            if (k % FRAME == 0) begin
                if (acc) begin
                    m_bcd = bcd_in; m_dp = dp_in;
                end else if (m_pv) begin
                    m_bcd = p_bcd; m_dp = p_dp;
                    m_pv = 0; m_ready = 1;
                end
            end else if (acc) begin
                p_bcd = bcd_in; p_dp = dp_in;
                m_pv = 1; m_ready = 0;
            end
        end
    endtask

    task automatic model_check();
        int p, slot;
        logic [3:0]  e_an, dig;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic [15:0] upper;
        p = k % FRAME;
        slot = p / SLOT;
        e_an = 4'hF; e_seg = '0; e_dp = 1'b0;
        if ((p % SLOT) >= BC) begin
            e_an  = 4'hF & ~(4'b0001 << slot);
            upper = m_bcd >> (4 * slot);
            dig   = upper[3:0];
            e_seg = (m_lz && slot != 0 && upper == 0) ? 7'b0 : glyph(dig);
            e_dp  = m_dp[slot];
        end
        total++;
        if (an !== e_an || seg !== e_seg || dp !== e_dp ||
            ready !== m_ready) begin
            bad++;
            $display("FAIL model k=%0d an=%b/%b seg=%b/%b dp=%b/%b rdy=%b/%b",
                     k, an, e_an, seg, e_seg, dp, e_dp, ready, m_ready);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        model_check();
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic wait_p(input int target);
        int n = 0;
        while ((k % FRAME) != target && n < 2 * FRAME) begin
            step();
            n++;
        end
        if ((k % FRAME) != target) begin
            total++;
            bad++;
            $display("FAIL wait_p got=%0d want=%0d", k % FRAME, target);
        end
    endtask

    task automatic chk_frame(input string name, input logic [27:0] es,
                             input logic [3:0] ed);
        logic [6:0] s;
        for (int i = 0; i < ND; i++) begin
            wait_p(i * SLOT + 5);
            s = es[7*i +: 7];
            chk({name, "_seg"}, 32'(seg), 32'(s));
            chk({name, "_dp"}, 32'(dp), 32'(ed[i]));
            chk({name, "_an"}, 32'(an), 32'(4'hF & ~(4'b0001 << i)));
        end
    endtask

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  dpv;
        logic        lz;
        logic [27:0] eseg;
        logic [3:0]  edp;
    } vec_t;

    vec_t vt [6];

    initial begin
        // eseg is {idx3, idx2, idx1, idx0}
        vt[0] = '{16'h1234, 4'b0100, 1'b0,
                  {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}, 4'b0100};
        vt[1] = '{16'h0050, 4'b0000, 1'b1,
                  {7'b0000000, 7'b0000000, 7'b1011011, 7'b1111110}, 4'b0000};
        vt[2] = '{16'h0050, 4'b0000, 1'b0,
                  {7'b1111110, 7'b1111110, 7'b1011011, 7'b1111110}, 4'b0000};
        vt[3] = '{16'hFA09, 4'b0000, 1'b1,
                  {7'b0000000, 7'b0000000, 7'b1111110, 7'b1111011}, 4'b0000};
        vt[4] = '{16'h0000, 4'b1111, 1'b1,
                  {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}, 4'b1111};
        vt[5] = '{16'h6789, 4'b0001, 1'b0,
                  {7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011}, 4'b0001};

        rst = 1'b1; load = 1'b0; lz_en = 1'b0;
        bcd_in = '0; dp_in = '0;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h0);
        chk("rst_dp", 32'(dp), 32'h0);
        chk("rst_ready", 32'(ready), 32'h1);

        // Idle scan pattern from reset.
        step();
        chk("idle_an1", 32'(an), 32'hF);
        step();
        chk("idle_an2", 32'(an), 32'hE);
        chk("idle_seg2", 32'(seg), 32'(7'b1111110));
        wait_p(9);
        chk("idle_an9", 32'(an), 32'hE);
        step();
        chk("idle_an10", 32'(an), 32'hF);
        wait_p(12);
        chk("idle_an12", 32'(an), 32'hD);
        wait_p(32);
        chk("idle_an32", 32'(an), 32'h7);
        wait_p(2);
        chk("idle_an42", 32'(an), 32'hE);

        // Table: mid-frame load, ignored second load, next-frame content.
        for (int v = 0; v < 6; v++) begin
            lz_en = vt[v].lz;
            wait_p(13);
            load = 1'b1; bcd_in = vt[v].bcd; dp_in = vt[v].dpv;
            step();
            load = 1'b0;
            chk("ready_drop", 32'(ready), 32'h0);
            step();
            load = 1'b1; bcd_in = 16'h8888; dp_in = 4'hA;
            step();
            load = 1'b0;
            chk("ready_low", 32'(ready), 32'h0);
            wait_p(0);
            chk("ready_back", 32'(ready), 32'h1);
            chk_frame("vec", vt[v].eseg, vt[v].edp);
        end

        // Load exactly on the commit edge.
        lz_en = 1'b0;
        wait_p(FRAME - 1);
        load = 1'b1; bcd_in = 16'h4321; dp_in = 4'b1000;
        step();
        load = 1'b0;
        chk("commit_ready", 32'(ready), 32'h1);
        chk_frame("commit",
                  {7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000}, 4'b1000);
        chk("commit_ready2", 32'(ready), 32'h1);

        // Reset in mid-frame with a pending load.
        wait_p(5);
        load = 1'b1; bcd_in = 16'h8888; dp_in = 4'hF;
        step();
        load = 1'b0;
        wait_p(17);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_an", 32'(an), 32'hF);
        chk("mrst_seg", 32'(seg), 32'h0);
        chk("mrst_ready", 32'(ready), 32'h1);
        chk_frame("mrst",
                  {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110}, 4'b0000);
        wait_p(0);
        chk_frame("mrst2",
                  {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110}, 4'b0000);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            load   = ($urandom_range(7) == 0);
            bcd_in = 16'($urandom);
            dp_in  = 4'($urandom);
            if ($urandom_range(63) == 0) lz_en = ~lz_en;
            rst    = ($urandom_range(799) == 0);
            step();
        end
        rst = 1'b0; load = 1'b0;
        repeat (FRAME) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (2..8).
REQ-002 The block SHALL have parameter REFRESH_DIV, default 50000, clocks each digit is lit (>=2).
REQ-003 The block SHALL have parameter BLANK_CYCLES, default 4, anti-ghosting dead clocks before each digit (>=1).
REQ-004 clk  input  1  single system clock, all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 load  input  1  request to accept new display data.
REQ-007 ready  output  1  high when a load is accepted this cycle.
REQ-008 bcd_in  input  4*NUM_DIGITS  BCD digits; bits [3:0] form digit 0, the least significant.
REQ-009 dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit.
REQ-010 lz_en  input  1  leading-zero suppression enable, sampled live every cycle.
REQ-011 seg  output  7  segments {a,b,c,d,e,f,g}, bit 6 = a, active-high.
REQ-012 dp  output  1  decimal point of the digit being lit, active-high.
REQ-013 an  output  NUM_DIGITS  digit enables, active-low, at most one bit low.

Function
REQ-014 The FSM SHALL have states BLANK and SHOW, plus a digit index idx (0..NUM_DIGITS-1) and a phase counter.
REQ-015 BLANK SHALL last exactly BLANK_CYCLES clocks with an all ones, seg 0 and dp 0, then go to SHOW with the same idx.
REQ-016 SHOW SHALL last exactly REFRESH_DIV clocks with an[idx] = 0, then go to BLANK with idx+1, wrapping NUM_DIGITS-1 to 0.
REQ-017 Frame length SHALL be NUM_DIGITS*(BLANK_CYCLES+REFRESH_DIV) clocks; scanning SHALL be continuous and free-running.
REQ-018 All outputs SHALL be registered and SHALL change on the same edge as the state/idx they reflect.
REQ-019 In SHOW, seg SHALL be the standard decode of digit idx from the display register: 0-9 normal glyphs, 6 with tail a, 7 = a,b,c, 9 with tail d.
REQ-020 Codes 10-15 SHALL decode as seg = 0 (blank); dp still follows dp_in.
REQ-021 With lz_en = 1, a zero digit SHALL show seg = 0 when every more significant digit is also zero; digit 0 is never suppressed.
REQ-022 Handshake: load && ready at an edge SHALL capture bcd_in and dp_in into a pending register, and ready SHALL be 0 from the next cycle.
REQ-023 The commit edge is the edge where SHOW of idx NUM_DIGITS-1 ends; pending SHALL copy to the display register there, and ready SHALL be 1 from the next cycle.
REQ-024 Display data SHALL never change mid-frame, so there is no tearing.
REQ-025 A load accepted on the commit edge itself SHALL write directly into the display register, and ready SHALL stay 1.
REQ-026 load while ready = 0 SHALL be ignored, with no queuing.

Reset
REQ-027 rst SHALL force the state to BLANK, idx 0, phase 0, an all ones, seg 0, dp 0, ready 1, display and pending 0, pending-valid 0, with outputs valid the cycle after reset.
REQ-028 rst asserted mid-frame or mid-handshake SHALL discard the pending data, with no commit.
REQ-029 After reset is released, the first SHOW of idx 0 SHALL begin BLANK_CYCLES clocks later.

Structure
REQ-030 Package seven_seg_pkg SHALL hold the state enum (BLANK, SHOW) and the 10-entry glyph constant table plus the blank-glyph constant.
REQ-031 The BCD-to-segment decode SHALL be one combinational sub-module, seg7_decode (4-bit in, 7-bit seg out, blank for codes 10-15).
REQ-032 Sequencer, handshake and leading-zero logic SHALL stay in the top module.

Verification
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2 (frame = 40 clocks).
REQ-033 Reset, then idle -> an = 1111 for 2 clocks, then 1110 for 8, 1111 for 2, 1101 for 8 ... 0111, repeating with period 40; seg = 7'b1111110 in each SHOW.
REQ-034 Load bcd_in 16'h1234, dp_in 4'b0100 mid-frame -> ready = 0 until the commit edge, then the next frame shows 4,3,2,1 on idx 0..3 (seg 0110011, 1111001, 1101101, 0110000) and dp = 1 only while an = 1011.
REQ-035 Load 16'h0050 with lz_en = 1 -> idx 3 and idx 2 blank, idx 1 = 5 (1011011), idx 0 = 0 (1111110); with lz_en = 0, all digits show.
REQ-036 Load 16'hFA09 -> idx 3 and idx 2 show seg 0, idx 1 = 0, idx 0 = 9 (1111011); a second load while ready = 0 is ignored.
REQ-037 Load asserted exactly on the commit edge -> the data appears in the immediately following frame, and ready never drops.
REQ-038 rst pulsed at clock 17 of a frame with a pending load -> outputs return to reset values, and no data from the discarded load is ever displayed.
